// File: rtl/dma_engine_param_if.sv
// Bus bundle for the DMA engine: Avalon-MM control slave plus read and write
// masters. The master modport is the engine side, slave the environment side.
interface dma_engine_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              iChipselect;
  logic              iRead;
  logic              iWrite;
  logic [2:0]        iAddress;
  logic [31:0]       iWritedata;
  logic [31:0]       oReaddata;
  logic              oIrq;
  logic              oRM_read;
  logic [ADDR_W-1:0] oRM_readaddress;
  logic              iRM_waitrequest;
  logic              iRM_readdatavalid;
  logic [DATA_W-1:0] iRM_readdata;
  logic              oWM_write;
  logic [ADDR_W-1:0] oWM_writeaddress;
  logic [DATA_W-1:0] oWM_writedata;
  logic              iWM_waitrequest;

  modport master (
    input  iChipselect, iRead, iWrite, iAddress, iWritedata,
    output oReaddata, oIrq,
    output oRM_read, oRM_readaddress,
    input  iRM_waitrequest, iRM_readdatavalid, iRM_readdata,
    output oWM_write, oWM_writeaddress, oWM_writedata,
    input  iWM_waitrequest
  );

  modport slave (
    output iChipselect, iRead, iWrite, iAddress, iWritedata,
    input  oReaddata, oIrq,
    input  oRM_read, oRM_readaddress,
    output iRM_waitrequest, iRM_readdatavalid, iRM_readdata,
    input  oWM_write, oWM_writeaddress, oWM_writedata,
    output iWM_waitrequest
  );
endinterface

// File: rtl/dma_engine_param.sv
// Single-channel memory-to-memory DMA engine. Reads are issued against a
// credit (FIFO occupancy + outstanding reads) so the show-ahead FIFO can
// never overflow; the write master drains the FIFO head.
module dma_engine_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input logic               iClk,
  input logic               iReset_n,
  dma_engine_param_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, stateNext;

  logic [ADDR_W-1:0] srcReg, dstReg, rdAddr, wrAddr;
  logic [LEN_W-1:0]  lenReg, rdIssued, wrAcc, wrAccNext;
  logic              srcFixed, dstFixed, irqEn, done, aborted;
  logic [CW-1:0]     outst, fifoCnt;
  logic [PW-1:0]     rdPtr, wrPtr;
  logic              drainRd, drainWr;
  logic [31:0]       readdata, rdMux;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic regWr, regRd, startReq, abortReq, credit;
  logic rmRead, wmWrite, rmAcc, wmAcc, rdRet, push, pop, lastWr, flush;

  assign regWr     = bus.iChipselect & bus.iWrite;
  assign regRd     = bus.iChipselect & bus.iRead;
  assign startReq  = regWr && bus.iAddress == 3'd3 && bus.iWritedata[0] && state == IDLE;
  assign abortReq  = regWr && bus.iAddress == 3'd3 && bus.iWritedata[4] && state == RUN;
  assign credit    = ({1'b0, fifoCnt} + {1'b0, outst}) < (CW + 1)'(FIFO_DEPTH);
  // In DRAIN only a request already stalled at abort time is kept alive.
  assign rmRead    = (state == RUN && rdIssued < lenReg && credit) || (state == DRAIN && drainRd);
  assign wmWrite   = (state == RUN && fifoCnt != '0) || (state == DRAIN && drainWr);
  assign rmAcc     = rmRead & ~bus.iRM_waitrequest;
  assign wmAcc     = wmWrite & ~bus.iWM_waitrequest;
  assign rdRet     = bus.iRM_readdatavalid && outst != '0 && state != IDLE;
  assign push      = rdRet && state == RUN;
  assign pop       = wmAcc;
  assign wrAccNext = wrAcc + LEN_W'(1);
  assign lastWr    = state == RUN && wmAcc && wrAccNext == lenReg;
  assign flush     = state == DRAIN && stateNext == IDLE;

  assign bus.oRM_read         = rmRead;
  assign bus.oRM_readaddress  = rdAddr;
  assign bus.oWM_write        = wmWrite;
  assign bus.oWM_writeaddress = wrAddr;
  assign bus.oWM_writedata    = wmWrite ? mem[rdPtr] : '0;
  assign bus.oReaddata        = readdata;
  assign bus.oIrq             = irqEn & (done | aborted);

  // Control register read mux
  always_comb begin
    rdMux = '0;
    case (bus.iAddress)
      3'd0: rdMux = 32'(srcReg);
      3'd1: rdMux = 32'(dstReg);
      3'd2: rdMux = 32'(lenReg);
      3'd3: rdMux = {28'd0, irqEn, dstFixed, srcFixed, 1'b0};
      3'd4: rdMux = {29'd0, aborted, done, state != IDLE};
      3'd5: rdMux = 32'(LEN_W'(lenReg - wrAcc));
      default: rdMux = '0;
    endcase
  end

  // State register
  always_ff @(posedge iClk) begin
    if (!iReset_n) state <= IDLE;
    else           state <= stateNext;
  end

  // Next-state: completion wins over a same-cycle abort
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startReq && lenReg != '0) stateNext = RUN;
      RUN:     if (lastWr) stateNext = IDLE;
               else if (abortReq) stateNext = DRAIN;
      DRAIN:   if (outst == '0 && !drainRd && !drainWr) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Registers, address/count tracking, FIFO pointers
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      srcReg <= '0; dstReg <= '0; lenReg <= '0;
      srcFixed <= 1'b0; dstFixed <= 1'b0; irqEn <= 1'b0;
      done <= 1'b0; aborted <= 1'b0;
      rdAddr <= '0; wrAddr <= '0; rdIssued <= '0; wrAcc <= '0;
      outst <= '0; fifoCnt <= '0; rdPtr <= '0; wrPtr <= '0;
      drainRd <= 1'b0; drainWr <= 1'b0; readdata <= '0;
    end else begin
      if (regWr && state == IDLE) begin
        case (bus.iAddress)
          3'd0: srcReg <= bus.iWritedata[ADDR_W-1:0];
          3'd1: dstReg <= bus.iWritedata[ADDR_W-1:0];
          3'd2: begin lenReg <= bus.iWritedata[LEN_W-1:0]; wrAcc <= '0; end
          3'd3: begin
            srcFixed <= bus.iWritedata[1];
            dstFixed <= bus.iWritedata[2];
            irqEn    <= bus.iWritedata[3];
          end
          default: ;
        endcase
      end
      if (regWr && bus.iAddress == 3'd4) begin
        if (bus.iWritedata[1]) done    <= 1'b0;
        if (bus.iWritedata[2]) aborted <= 1'b0;
      end
      if (startReq) begin
        rdAddr <= srcReg; wrAddr <= dstReg;
        rdIssued <= '0; wrAcc <= '0;
        aborted <= 1'b0;
        done <= (lenReg == '0);
      end
      if (rmAcc) begin
        if (!srcFixed) rdAddr <= rdAddr + STEP;
        rdIssued <= rdIssued + LEN_W'(1);
      end
      if (wmAcc) begin
        if (!dstFixed) wrAddr <= wrAddr + STEP;
        wrAcc <= wrAccNext;
      end
      if (lastWr) done <= 1'b1;
      outst <= outst + CW'(rmAcc) - CW'(rdRet);
      if (abortReq && !lastWr) begin
        drainRd <= rmRead & bus.iRM_waitrequest;
        drainWr <= wmWrite & bus.iWM_waitrequest;
      end else begin
        if (rmAcc) drainRd <= 1'b0;
        if (wmAcc) drainWr <= 1'b0;
      end
      if (flush) begin
        aborted <= 1'b1;
        fifoCnt <= '0; rdPtr <= '0; wrPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PW'(1);
        if (pop)  rdPtr <= rdPtr + PW'(1);
        fifoCnt <= fifoCnt + CW'(push) - CW'(pop);
      end
      readdata <= regRd ? rdMux : '0;
    end
  end

  // FIFO storage, written on each accepted read return
  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr] <= bus.iRM_readdata;
  end
endmodule

// File: tb/tb_dma_engine_param.sv
// Bench for dma_engine_param: memory model with configurable stalls and read
// latency; expected writes queued at programming time and checked on accept.
module tb_dma_engine_param;
  localparam int DW = 32, AD = 32, LW = 16, FD = 4;

  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  always #5 iClk = ~iClk;

  dma_engine_param_if #(.DATA_W(DW), .ADDR_W(AD)) bus();
  dma_engine_param #(.DATA_W(DW), .ADDR_W(AD), .LEN_W(LW), .FIFO_DEPTH(FD)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .bus(bus)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] addr; int due; } rd_t;
  wr_t expQ[$];
  rd_t rdQ[$];

  int nCmp = 0, nBad = 0;
  int cyc = 0;
  int rmWaitPct = 0, wmWaitPct = 0, lat = 1;
  int rdAcc = 0, wrAcc = 0, maxFly = 0, rdCyc = 0, wrCyc = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memVal(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]} + 32'h0101_0101;
  endfunction

  always @(posedge iClk) cyc++;

  // Memory model: decide stalls/returns for the coming edge, score writes
  always @(negedge iClk) begin
    wr_t e;
    if (!iReset_n) begin
      rdQ.delete();
      bus.iRM_waitrequest = 1'b0; bus.iWM_waitrequest = 1'b0;
      bus.iRM_readdatavalid = 1'b0; bus.iRM_readdata = '0;
    end else begin
      bus.iRM_waitrequest = (rmWaitPct != 0) && ($urandom_range(99) < rmWaitPct);
      bus.iWM_waitrequest = (wmWaitPct != 0) && ($urandom_range(99) < wmWaitPct);
      if (rdQ.size() > 0 && rdQ[0].due <= cyc) begin
        bus.iRM_readdatavalid = 1'b1;
        bus.iRM_readdata = memVal(rdQ[0].addr);
        void'(rdQ.pop_front());
      end else begin
        bus.iRM_readdatavalid = 1'b0;
        bus.iRM_readdata = '0;
      end
      if (bus.oRM_read) rdCyc++;
      if (bus.oWM_write) wrCyc++;
      if (bus.oRM_read && !bus.iRM_waitrequest) begin
        rdQ.push_back('{bus.oRM_readaddress, cyc + lat});
        rdAcc++;
      end
      if (bus.oWM_write && !bus.iWM_waitrequest) begin
        wrAcc++;
        if (expQ.size() != 0) e = expQ.pop_front();
        else e = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
        chk("wr_addr", bus.oWM_writeaddress, e.addr);
        chk("wr_data", bus.oWM_writedata, e.data);
      end
      if (rdAcc - wrAcc > maxFly) maxFly = rdAcc - wrAcc;
    end
  end

  task automatic busWr(input logic [2:0] a, input logic [31:0] d);
    @(posedge iClk); #2;
    bus.iChipselect = 1'b1; bus.iWrite = 1'b1; bus.iAddress = a; bus.iWritedata = d;
    @(posedge iClk); #2;
    bus.iChipselect = 1'b0; bus.iWrite = 1'b0;
  endtask

  task automatic busRd(input logic [2:0] a, output logic [31:0] d);
    @(posedge iClk); #2;
    bus.iChipselect = 1'b1; bus.iRead = 1'b1; bus.iAddress = a;
    @(posedge iClk); #2;
    bus.iChipselect = 1'b0; bus.iRead = 1'b0;
    d = bus.oReaddata;
  endtask

  task automatic waitIdle(string tag);
    logic [31:0] s;
    int n = 0;
    do begin busRd(3'd4, s); n++; end while (s[0] && n < 3000);
    if (s[0]) chk({tag, "_timeout"}, s[0], 1'b0);
  endtask

  task automatic startXfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input bit sf, input bit df, input bit irq);
    for (int i = 0; i < len; i++)
      expQ.push_back('{df ? dst : dst + 32'(4 * i), memVal(sf ? src : src + 32'(4 * i))});
    rdAcc = 0; wrAcc = 0; maxFly = 0;
    busWr(3'd0, src); busWr(3'd1, dst); busWr(3'd2, 32'(len));
    busWr(3'd3, {28'd0, irq, df, sf, 1'b1});
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int n;
    bus.iChipselect = 1'b0; bus.iRead = 1'b0; bus.iWrite = 1'b0;
    bus.iAddress = '0; bus.iWritedata = '0;
    iReset_n = 1'b0;
    repeat (3) @(posedge iClk);
    #2;
    chk("rst_outs", |{bus.oRM_read, bus.oWM_write, bus.oIrq, bus.oReaddata,
                      bus.oRM_readaddress, bus.oWM_writeaddress, bus.oWM_writedata}, 1'b0);
    iReset_n = 1'b1;
    busRd(3'd0, d); chk("rst_src", d, 0);
    busRd(3'd3, d); chk("rst_ctrl", d, 0);
    busRd(3'd4, d); chk("rst_status", d, 0);

    // basic 8-word copy
    busWr(3'd2, 32'd8);
    busRd(3'd5, d); chk("remain_idle", d, 8);
    startXfer(32'h1000, 32'h2000, 8, 0, 0, 0);
    waitIdle("t1");
    busRd(3'd4, d); chk("t1_status", d, 32'h2);
    busRd(3'd5, d); chk("t1_remain", d, 0);
    chk("t1_sb_left", expQ.size(), 0);
    chk("t1_writes", wrAcc, 8);

    // random stalls, 3-cycle latency, credit bound
    rmWaitPct = 40; wmWaitPct = 40; lat = 3;
    startXfer(32'h4000, 32'h8000, 100, 0, 0, 0);
    busRd(3'd4, d); chk("t2_busy", d[0], 1'b1);
    waitIdle("t2");
    chk("t2_sb_left", expQ.size(), 0);
    chk("t2_credit_over", maxFly > FD, 1'b0);
    busRd(3'd4, d); chk("t2_status", d, 32'h2);

    // fixed-address modes and address wrap
    rmWaitPct = 0; wmWaitPct = 0; lat = 1;
    startXfer(32'h0100, 32'h0F00, 5, 0, 1, 0);
    waitIdle("t3d"); chk("t3d_sb_left", expQ.size(), 0);
    startXfer(32'h0200, 32'h0E00, 5, 1, 0, 0);
    waitIdle("t3s"); chk("t3s_sb_left", expQ.size(), 0);
    startXfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 4, 0, 0, 0);
    waitIdle("t3w"); chk("t3w_sb_left", expQ.size(), 0);

    // abort mid-transfer
    wmWaitPct = 50; lat = 3;
    startXfer(32'h10000, 32'h20000, 20, 0, 0, 0);
    n = 0;
    while (wrAcc < 3 && n < 500) begin @(posedge iClk); n++; end
    chk("t4_reach3", wrAcc >= 3, 1'b1);
    busWr(3'd3, 32'h10);
    n = wrAcc;
    waitIdle("t4");
    chk("t4_extra_wr", (wrAcc - n) <= 1, 1'b1);
    busRd(3'd4, d); chk("t4_status", d, 32'h4);
    chk("t4_rd_drained", rdQ.size(), 0);
    busRd(3'd5, d); chk("t4_remain", d, 32'(20 - wrAcc));
    expQ.delete();
    wmWaitPct = 0;
    startXfer(32'h30000, 32'h40000, 3, 0, 0, 0);
    waitIdle("t4f"); chk("t4f_sb_left", expQ.size(), 0);

    // LEN=0 with IRQ
    lat = 1;
    busWr(3'd2, 32'd0);
    rdCyc = 0; wrCyc = 0;
    busWr(3'd3, 32'h9);
    chk("t5_irq", bus.oIrq, 1'b1);
    busRd(3'd4, d); chk("t5_status", d, 32'h2);
    chk("t5_no_traffic", rdCyc + wrCyc, 0);
    busWr(3'd4, 32'h2);
    chk("t5_irq_clr", bus.oIrq, 1'b0);

    // START/LEN writes while busy ignored
    wmWaitPct = 60;
    startXfer(32'h5000, 32'h6000, 12, 0, 0, 0);
    busWr(3'd2, 32'd3);
    busWr(3'd3, 32'h1);
    busRd(3'd2, d); chk("t6_len_kept", d, 12);
    waitIdle("t6");
    chk("t6_sb_left", expQ.size(), 0);
    chk("t6_writes", wrAcc, 12);
    busRd(3'd5, d); chk("t6_remain", d, 0);

    // reset mid-run
    rmWaitPct = 30; lat = 2;
    startXfer(32'h7000, 32'h9000, 40, 0, 0, 0);
    repeat (10) @(posedge iClk);
    #2 iReset_n = 1'b0;
    @(posedge iClk); #2;
    chk("t6_rst_outs", |{bus.oRM_read, bus.oWM_write, bus.oIrq, bus.oReaddata,
                         bus.oRM_readaddress, bus.oWM_writeaddress, bus.oWM_writedata}, 1'b0);
    @(posedge iClk); #2 iReset_n = 1'b1;
    expQ.delete();
    busRd(3'd4, d); chk("t6_rst_status", d, 0);
    busRd(3'd0, d); chk("t6_rst_src", d, 0);
    rmWaitPct = 0; wmWaitPct = 0; lat = 1;
    startXfer(32'hA000, 32'hB000, 2, 0, 0, 0);
    waitIdle("t6p"); chk("t6p_sb_left", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
